// File: rtl/data_bus_ram.sv
// Word-organised RAM behind a CS/WR_RD request bus: accepted requests pass through WAIT
// wait states, a single access cycle, then hold in RELEASE until CS is withdrawn.
module data_bus_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CS,
  input  logic                WR_RD,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [DATA_W-1:0]   Data_BUS_WRITE,
  output logic [DATA_W-1:0]   Data_BUS_READ,
  output logic                READY,
  output logic                ERR
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAITING = 2'd1;
  localparam logic [1:0] S_ACCESS  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  // Handshake: a request is taken on the first edge with CS=1 in IDLE; READY (with ERR)
  // pulses for exactly one cycle when the access completes, and the next request is only
  // taken after CS has been seen low at least once in RELEASE.
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_word_idx;
  logic [63:0]       w_idx_ext;
  logic [MEM_AW-1:0] w_mem_idx;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_err;
  logic              w_do_write;

  assign w_word_idx     = r_addr[ADDR_W-1:OFF_W];
  assign w_idx_ext      = 64'(w_word_idx);
  assign w_mem_idx      = w_word_idx[MEM_AW-1:0];
  assign w_misaligned   = |r_addr[OFF_W-1:0];
  assign w_out_of_range = (w_idx_ext >= 64'(DEPTH));
  assign w_err          = w_misaligned | w_out_of_range;
  assign w_do_write     = !RST && (r_state == S_ACCESS) && r_wr && !w_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (CS) begin
            r_addr  <= ADDR;
            r_be    <= BE;
            r_wr    <= WR_RD;
            r_wdata <= Data_BUS_WRITE;
            r_cnt   <= WAIT_CNT;
            r_state <= (WAIT_CNT != 4'd0) ? S_WAITING : S_ACCESS;
          end
        end
        S_WAITING: begin
          // Counter hits zero on the same edge that moves us into ACCESS.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          r_ready <= 1'b1;
          r_err   <= w_err;
          if (!r_wr) r_rdata <= w_err ? '0 : r_mem[w_mem_idx];
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!CS) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so RST never clears contents.
  always_ff @(posedge CLK) begin
    if (w_do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (r_be[b]) r_mem[w_mem_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

  assign Data_BUS_READ = r_rdata;
  assign READY         = r_ready;
  assign ERR           = r_err;

endmodule

// File: tb/tb_data_bus_ram.sv
// Directed bench for data_bus_ram: three instances (WAIT=2, 0, 15) sharing the bus inputs,
// each with its own chip select.
module tb_data_bus_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cs_v;
  logic        wr_rd;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rd_v [3];
  logic [2:0]  ready_v;
  logic [2:0]  err_v;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd [3];
  int          wait_of [3] = '{2, 0, 15};

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [18];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  data_bus_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT(2)) u_dut_w2 (
    .CLK(clk), .RST(rst), .CS(cs_v[0]), .WR_RD(wr_rd), .ADDR(addr), .BE(be),
    .Data_BUS_WRITE(wdata), .Data_BUS_READ(rd_v[0]), .READY(ready_v[0]), .ERR(err_v[0]));

  data_bus_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT(0)) u_dut_w0 (
    .CLK(clk), .RST(rst), .CS(cs_v[1]), .WR_RD(wr_rd), .ADDR(addr), .BE(be),
    .Data_BUS_WRITE(wdata), .Data_BUS_READ(rd_v[1]), .READY(ready_v[1]), .ERR(err_v[1]));

  data_bus_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT(15)) u_dut_w15 (
    .CLK(clk), .RST(rst), .CS(cs_v[2]), .WR_RD(wr_rd), .ADDR(addr), .BE(be),
    .Data_BUS_WRITE(wdata), .Data_BUS_READ(rd_v[2]), .READY(ready_v[2]), .ERR(err_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: called just after a falling edge with the target instance in IDLE.
  // Returns just after a falling edge with that instance back in IDLE.
  task automatic run_txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] dat, input logic exp_err, input logic [31:0] exp_rd,
                         input string tag);
    int          lat;
    logic [31:0] exp;
    if (!w) exp_q.push_back(exp_rd);
    wr_rd   = w;
    addr    = a;
    be      = b;
    wdata   = dat;
    cs_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Once accepted the request must be immune to bus changes.
    cs_v[d] = 1'b0;
    wr_rd   = ~w;
    addr    = $urandom;
    be      = 4'($urandom);
    wdata   = $urandom;
    lat = 0;
    while (ready_v[d] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(wait_of[d] + 1));
    check({tag, " err"}, {31'd0, err_v[d]}, {31'd0, exp_err});
    if (!w) begin
      exp = exp_q.pop_front();
      check({tag, " rdata"}, rd_v[d], exp);
      last_rd[d] = exp;
    end else begin
      check({tag, " rdata hold"}, rd_v[d], last_rd[d]);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready pulse"}, {31'd0, ready_v[d]}, 32'd0);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'h5, 32'h11223344, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[4]  = '{1'b0, 32'h0000_1002, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0013, 4'hF, 32'h0BADF00D, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        1'b0, 32'hDE22BE44};
    vecs[8]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h12345678, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,        1'b0, 32'h12345678};
    vecs[11] = '{1'b1, 32'h0000_0020, 4'hF, 32'h01020304, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_0FFC, 4'h9, 32'h11000022, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,        1'b0, 32'h11FEF022};
    vecs[15] = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,        1'b0, 32'h01020304};
    vecs[17] = '{1'b0, 32'h0000_0FFF, 4'h0, 32'h0,        1'b1, 32'h0};

    rst   = 1'b1;
    cs_v  = 3'b000;
    wr_rd = 1'b0;
    addr  = 32'h0;
    be    = 4'h0;
    wdata = 32'h0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", {29'd0, ready_v}, 32'd0);
    check("reset err", {29'd0, err_v}, 32'd0);
    check("reset rdata w2", rd_v[0], 32'h0);
    check("reset rdata w0", rd_v[1], 32'h0);
    check("reset rdata w15", rd_v[2], 32'h0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run_txn(0, vecs[i].wr, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].e, vecs[i].rd,
              $sformatf("vec%0d", i));
    end

    // CS held high for 10 cycles: one transaction only.
    wr_rd   = 1'b0;
    addr    = 32'h10;
    cs_v[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_v[0] === 1'b1) cnt++;
    end
    check("held cs ready count", 32'(cnt), 32'd1);
    check("held cs rdata", rd_v[0], 32'hDE22BE44);
    last_rd[0] = 32'hDE22BE44;
    cs_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run_txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h12345678, "after held cs");

    // Reset during WAITING of a write, then reset with CS high.
    wr_rd   = 1'b1;
    addr    = 32'h20;
    be      = 4'hF;
    wdata   = 32'hA5A5A5A5;
    cs_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs_v[0] = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    cs_v[0] = 1'b0;
    check("abort rdata cleared", rd_v[0], 32'h0);
    check("abort ready low", {31'd0, ready_v[0]}, 32'd0);
    check("abort err low", {31'd0, err_v[0]}, 32'd0);
    last_rd[0] = 32'h0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_v[0] === 1'b1) cnt++;
    end
    check("abort no ready", 32'(cnt), 32'd0);
    run_txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h01020304, "abort readback");

    // Latency extremes.
    run_txn(1, 1'b1, 32'h40, 4'hF, 32'h0F1E2D3C, 1'b0, 32'h0, "w0 write");
    run_txn(1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0F1E2D3C, "w0 read");
    run_txn(1, 1'b0, 32'h1001, 4'h0, 32'h0, 1'b1, 32'h0, "w0 err read");
    run_txn(2, 1'b1, 32'h44, 4'hF, 32'h76543210, 1'b0, 32'h0, "w15 write");
    run_txn(2, 1'b0, 32'h44, 4'h0, 32'h0, 1'b0, 32'h76543210, "w15 read");
    run_txn(2, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h0, "w15 err read");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
